// File: rtl/viterbi_pkg.sv
// Shared types, sizes and trellis helpers for the 4-state, K=3 Viterbi path-metric stage.
package viterbi_pkg;

    localparam int unsigned NUM_STATES = 4;
    localparam int unsigned BM_W       = 2;
    localparam int unsigned PM_W       = 8;

    typedef logic [BM_W-1:0] bm_t;
    typedef logic [PM_W-1:0] pm_t;
    typedef logic [1:0]      state_idx_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} pmu_state_t;

    // Next state ns = {u, s[1]}, so both predecessors share s[1] = ns[0].
    function automatic state_idx_t pred0(input state_idx_t ns);
        return {ns[0], 1'b0};
    endfunction

    function automatic state_idx_t pred1(input state_idx_t ns);
        return {ns[0], 1'b1};
    endfunction

endpackage

// File: rtl/acs_cell.sv
// Combinational add / saturate / compare / select for one next-state of the trellis.
module acs_cell
    import viterbi_pkg::*;
(
    input  logic [PM_W-1:0] pm0_i,
    input  logic [PM_W-1:0] pm1_i,
    input  logic [BM_W-1:0] bm0_i,
    input  logic [BM_W-1:0] bm1_i,
    output logic [PM_W-1:0] pm_sel_o,
    output logic            dec_o,
    output logic            msb_o
);

    logic [PM_W:0]   sum0;
    logic [PM_W:0]   sum1;
    logic [PM_W-1:0] c0;
    logic [PM_W-1:0] c1;

    assign sum0 = {1'b0, pm0_i} + {{(PM_W + 1 - BM_W){1'b0}}, bm0_i};
    assign sum1 = {1'b0, pm1_i} + {{(PM_W + 1 - BM_W){1'b0}}, bm1_i};

    assign c0 = sum0[PM_W] ? {PM_W{1'b1}} : sum0[PM_W-1:0];
    assign c1 = sum1[PM_W] ? {PM_W{1'b1}} : sum1[PM_W-1:0];

    // Strict compare: a tie keeps predecessor 0.
    assign dec_o    = (c1 < c0);
    assign pm_sel_o = dec_o ? c1 : c0;
    assign msb_o    = pm_sel_o[PM_W-1];

endmodule

// File: rtl/viterbi_path_metric_unit.sv
// ACS / path-metric stage: four ACS cells, shared normalization, frame sequencing and argmin.
module viterbi_path_metric_unit
    import viterbi_pkg::*;
#(
    parameter int unsigned PM_INIT   = 32,
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         init_i,
    input  logic                         bm_valid_i,
    input  logic [NUM_STATES*2*BM_W-1:0] bm_in_i,
    output logic [NUM_STATES*PM_W-1:0]   pm_out_o,
    output logic [NUM_STATES-1:0]        dec_out_o,
    output logic                         dec_valid_o,
    output logic                         frame_last_o,
    output logic [1:0]                   best_state_o,
    output logic                         norm_pulse_o,
    output logic                         busy_o
);

    localparam int unsigned CntW = $clog2(FRAME_LEN + 1);
    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t LastCnt = cnt_t'(FRAME_LEN - 1);

    pmu_state_t                          state_q, state_d;
    cnt_t                                cnt_q, cnt_d;
    logic [NUM_STATES-1:0][PM_W-1:0]     pm_q, pm_d;
    logic [NUM_STATES-1:0]               dec_q, dec_d;
    logic                                dec_valid_q, dec_valid_d;
    logic                                frame_last_q, frame_last_d;
    logic                                norm_q, norm_d;

    logic [NUM_STATES-1:0][PM_W-1:0]     pm_sel;
    logic [NUM_STATES-1:0]               dec_sel;
    logic [NUM_STATES-1:0]               msb_sel;
    logic                                accept;
    logic                                norm_now;

    for (genvar g = 0; g < NUM_STATES; g++) begin : gen_acs
        localparam state_idx_t P0 = pred0(state_idx_t'(g));
        localparam state_idx_t P1 = pred1(state_idx_t'(g));

        acs_cell u_acs (
            .pm0_i    (pm_q[P0]),
            .pm1_i    (pm_q[P1]),
            .bm0_i    (bm_in_i[(g*2+0)*BM_W +: BM_W]),
            .bm1_i    (bm_in_i[(g*2+1)*BM_W +: BM_W]),
            .pm_sel_o (pm_sel[g]),
            .dec_o    (dec_sel[g]),
            .msb_o    (msb_sel[g])
        );
    end

    assign accept   = (state_q == RUN) && bm_valid_i && !init_i;
    assign norm_now = &msb_sel;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pm_d         = pm_q;
        dec_d        = dec_q;
        dec_valid_d  = 1'b0;
        frame_last_d = 1'b0;
        norm_d       = 1'b0;

        if (init_i) begin
            state_d = RUN;
            cnt_d   = '0;
            pm_d[0] = '0;
            for (int s = 1; s < NUM_STATES; s++) begin
                pm_d[s] = PM_W'(PM_INIT);
            end
        end else if (accept) begin
            dec_d       = dec_sel;
            dec_valid_d = 1'b1;
            norm_d      = norm_now;
            cnt_d       = cnt_q + cnt_t'(1);
            // Clearing the common MSB subtracts 2**(PM_W-1) from every metric at once.
            for (int s = 0; s < NUM_STATES; s++) begin
                pm_d[s] = norm_now ? {1'b0, pm_sel[s][PM_W-2:0]} : pm_sel[s];
            end
            if (cnt_q == LastCnt) begin
                frame_last_d = 1'b1;
                state_d      = DONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pm_q         <= '0;
            dec_q        <= '0;
            dec_valid_q  <= 1'b0;
            frame_last_q <= 1'b0;
            norm_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pm_q         <= pm_d;
            dec_q        <= dec_d;
            dec_valid_q  <= dec_valid_d;
            frame_last_q <= frame_last_d;
            norm_q       <= norm_d;
        end
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        logic [PM_W-1:0] min_v;
        min_v        = pm_q[0];
        best_state_o = 2'd0;
        for (int s = 1; s < NUM_STATES; s++) begin
            if (pm_q[s] < min_v) begin
                min_v        = pm_q[s];
                best_state_o = 2'(s);
            end
        end
    end

    assign pm_out_o     = pm_q;
    assign dec_out_o    = dec_q;
    assign dec_valid_o  = dec_valid_q;
    assign frame_last_o = frame_last_q;
    assign norm_pulse_o = norm_q;
    assign busy_o       = (state_q == RUN);

endmodule
